axi_reg_slave: RTL and testbench

AXI4 responder that terminates the 64-bit AXI4 master port of the JTAG-to-AXI bridge and drives the 128-bit register/memory backend. It is the slave-side counterpart to the master in `jtag`. Each AXI beat becomes one backend write or read strobe on the correct 64-bit lane of the 128-bit word. One transaction is in flight at a time, with alternating read/write arbitration.

---
 rtl/axi_reg_slave.sv | 207 ++++++++++++++++++++
 tb/tb_axi_reg_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_slave.sv
// AXI4 slave bridging 64-bit beats onto a 128-bit register backend.
// Optional start-address decode error: define AXI_SLV_DECERR_EN.
module axi_reg_slave #(
    parameter int unsigned RD_LAT     = 1,
    parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_axi_awid,
    input  logic [31:0]  s_axi_awaddr,
    input  logic [7:0]   s_axi_awlen,
    input  logic [2:0]   s_axi_awsize,
    input  logic [1:0]   s_axi_awburst,
    input  logic         s_axi_awvalid,
    output logic         s_axi_awready,
    input  logic [63:0]  s_axi_wdata,
    input  logic [7:0]   s_axi_wstrb,
    input  logic         s_axi_wlast,
    input  logic         s_axi_wvalid,
    output logic         s_axi_wready,
    output logic         s_axi_bid,
    output logic [1:0]   s_axi_bresp,
    output logic         s_axi_bvalid,
    input  logic         s_axi_bready,
    input  logic         s_axi_arid,
    input  logic [31:0]  s_axi_araddr,
    input  logic [7:0]   s_axi_arlen,
    input  logic [2:0]   s_axi_arsize,
    input  logic [1:0]   s_axi_arburst,
    input  logic         s_axi_arvalid,
    output logic         s_axi_arready,
    output logic         s_axi_rid,
    output logic [63:0]  s_axi_rdata,
    output logic [1:0]   s_axi_rresp,
    output logic         s_axi_rlast,
    output logic         s_axi_rvalid,
    input  logic         s_axi_rready,
    output logic [31:0]  WrAddr,
    output logic [127:0] WrData,
    output logic [15:0]  WrStrb,
    output logic         WrEn,
    output logic [31:0]  RdAddr,
    output logic         RdEn,
    input  logic [127:0] RdData
);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_DATA
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic [31:0] addr_nxt;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        id;
    logic [8:0]  beat;
    logic [3:0]  lat_cnt;
    logic        last_wr;
    logic        dec;
    logic [1:0]  bresp_q;
    logic        grant_w, grant_r;
    logic        w_hs, r_hs, rd_last, lat_done;
    logic        aw_bad, ar_bad;

`ifdef AXI_SLV_DECERR_EN
    assign aw_bad = s_axi_awaddr >= ADDR_LIMIT;
    assign ar_bad = s_axi_araddr >= ADDR_LIMIT;
`else
    logic unused_cfg;
    assign unused_cfg = ^ADDR_LIMIT;
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
`endif

    // Alternate on contention; last_wr clear after reset lets writes win.
    assign grant_w  = s_axi_awvalid && (!s_axi_arvalid || !last_wr);
    assign grant_r  = s_axi_arvalid && !grant_w;
    assign w_hs     = (state == WR_DATA) && s_axi_wvalid;
    assign r_hs     = (state == RD_DATA) && s_axi_rready;
    assign rd_last  = beat == {1'b0, len};
    assign lat_done = lat_cnt == 4'(RD_LAT);
    assign addr_nxt = (burst == 2'b00) ? addr : addr + (32'd1 << size);

    assign s_axi_wready  = state == WR_DATA;
    assign s_axi_bvalid  = state == WR_RESP;
    assign s_axi_bid     = id;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = state == RD_DATA;
    assign s_axi_rid     = id;
    assign s_axi_rlast   = s_axi_rvalid && rd_last;
    assign s_axi_rresp   = (s_axi_rvalid && dec) ? 2'b11 : 2'b00;
    assign RdEn          = (state == RD_REQ) && !dec;
    assign RdAddr        = {addr[31:4], 4'h0};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_w)      state_nxt = WR_DATA;
                else if (grant_r) state_nxt = RD_REQ;
            end
            WR_DATA: if (w_hs && s_axi_wlast) state_nxt = WR_RESP;
            WR_RESP: if (s_axi_bready) state_nxt = IDLE;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (lat_done) state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = rd_last ? IDLE : RD_REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction context, backend write strobes and read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_awready <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rdata   <= '0;
            WrAddr        <= '0;
            WrData        <= '0;
            WrStrb        <= '0;
            WrEn          <= 1'b0;
            addr          <= '0;
            len           <= '0;
            size          <= '0;
            burst         <= '0;
            id            <= 1'b0;
            beat          <= '0;
            lat_cnt       <= '0;
            last_wr       <= 1'b0;
            dec           <= 1'b0;
            bresp_q       <= '0;
        end else begin
            s_axi_awready <= 1'b0;
            s_axi_arready <= 1'b0;
            WrEn          <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_w) begin
                        s_axi_awready <= 1'b1;
                        addr    <= s_axi_awaddr;
                        len     <= s_axi_awlen;
                        size    <= s_axi_awsize;
                        burst   <= s_axi_awburst;
                        id      <= s_axi_awid;
                        dec     <= aw_bad;
                        beat    <= '0;
                        last_wr <= 1'b1;
                    end else if (grant_r) begin
                        s_axi_arready <= 1'b1;
                        addr    <= s_axi_araddr;
                        len     <= s_axi_arlen;
                        size    <= s_axi_arsize;
                        burst   <= s_axi_arburst;
                        id      <= s_axi_arid;
                        dec     <= ar_bad;
                        beat    <= '0;
                        last_wr <= 1'b0;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (!dec) begin
                            WrEn   <= 1'b1;
                            WrAddr <= {addr[31:4], 4'h0};
                            WrData <= {s_axi_wdata, s_axi_wdata};
                            WrStrb <= addr[3] ? {s_axi_wstrb, 8'h00}
                                              : {8'h00, s_axi_wstrb};
                        end
                        beat <= beat + 9'd1;
                        addr <= addr_nxt;
                        if (s_axi_wlast) begin
                            if (dec)                        bresp_q <= 2'b11;
                            else if (beat != {1'b0, len})   bresp_q <= 2'b10;
                            else                            bresp_q <= 2'b00;
                        end
                    end
                end
                RD_REQ: lat_cnt <= 4'd1;
                RD_WAIT: begin
                    if (lat_done) begin
                        if (dec)          s_axi_rdata <= '0;
                        else if (addr[3]) s_axi_rdata <= RdData[127:64];
                        else              s_axi_rdata <= RdData[63:0];
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RD_DATA: begin
                    if (r_hs && !rd_last) begin
                        addr <= addr_nxt;
                        beat <= beat + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_reg_slave.sv
// Directed self-checking bench for axi_reg_slave with RD_LAT = 2.
// Backend read model returns an address-derived pattern.
module tb_axi_reg_slave;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         awid, awvalid, awready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic         bid, bvalid, bready;
    logic [1:0]   bresp;
    logic         arid, arvalid, arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rid, rlast, rvalid, rready;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic [31:0]  wr_addr, rd_addr;
    logic [127:0] wr_data, rd_data;
    logic [15:0]  wr_strb;
    logic         wr_en, rd_en;

    int checks = 0;
    int errors = 0;
    int wren_cnt = 0;
    int rden_cnt = 0;
    logic [31:0]  rd_log [0:15];
    logic [127:0] q1 = '0;
    logic [127:0] q2 = '0;

    axi_reg_slave #(.RD_LAT(2), .ADDR_LIMIT(32'h0001_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .WrAddr(wr_addr), .WrData(wr_data), .WrStrb(wr_strb), .WrEn(wr_en),
        .RdAddr(rd_addr), .RdEn(rd_en), .RdData(rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {32'hAAAA_0000, a, 32'h5555_0000, a};
    endfunction

    // Backend: data valid exactly two cycles after RdEn, zero otherwise.
    always @(posedge clk) begin
        q1 <= rd_en ? pat(rd_addr) : '0;
        q2 <= q1;
        if (rd_en) begin
            rd_log[rden_cnt[3:0]] <= rd_addr;
            rden_cnt <= rden_cnt + 1;
        end
        if (wr_en) wren_cnt <= wren_cnt + 1;
    end
    assign rd_data = q2;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return awready;
            1: return arready;
            2: return wready;
            3: return bvalid;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_hi(input int sel, input string tag);
        int t = 0;
        while (sig(sel) !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 128'(sig(sel)), 128'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3; awburst = 2'b01;
        wdata = 0; wstrb = 0; wlast = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 3; arburst = 2'b01;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [7:0] l,
                            input logic i);
        awaddr = a; awlen = l; awid = i; awvalid = 1'b1;
        wait_hi(0, "awready");
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [7:0] l,
                            input logic i);
        araddr = a; arlen = l; arid = i; arvalid = 1'b1;
        wait_hi(1, "arready");
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s,
                          input logic l);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        wait_hi(2, "wready");
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [1:0] er, input logic ei,
                           input string tag);
        bready = 1'b1;
        wait_hi(3, "bvalid");
        chk({tag, "_bresp"}, 128'(bresp), 128'(er));
        chk({tag, "_bid"}, 128'(bid), 128'(ei));
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic r_beat(output logic [63:0] d, output logic l,
                          output logic i);
        rready = 1'b1;
        wait_hi(4, "rvalid");
        d = rdata; l = rlast; i = rid;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d, hold;
        logic        l, i;
        int          w0, r0;
        logic        g;
        logic [63:0] exp_d [0:3];
        logic [31:0] exp_a [0:3];

        exp_d[0] = 64'h5555_0000_0000_0200;
        exp_d[1] = 64'hAAAA_0000_0000_0200;
        exp_d[2] = 64'h5555_0000_0000_0210;
        exp_d[3] = 64'hAAAA_0000_0000_0210;
        exp_a[0] = 32'h200; exp_a[1] = 32'h200;
        exp_a[2] = 32'h210; exp_a[3] = 32'h210;

        do_reset();
        chk("rst_ready", {126'd0, awready, arready}, 128'd0);
        chk("rst_valid", {125'd0, wready, bvalid, rvalid}, 128'd0);
        chk("rst_strobe", {126'd0, wr_en, rd_en}, 128'd0);
        chk("rst_wr", {wr_addr, wr_strb, rd_addr}, 128'd0);
        chk("rst_wdata", wr_data, 128'd0);
        chk("rst_resp", {rdata, bresp, rresp, rid, bid, rlast}, 128'd0);

        // Single write to the high lane.
        w0 = wren_cnt;
        aw_phase(32'h108, 8'd0, 1'b1);
        w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        chk("w1_en", 128'(wr_en), 128'd1);
        chk("w1_addr", 128'(wr_addr), 128'h100);
        chk("w1_strb", 128'(wr_strb), 128'hFF00);
        chk("w1_data", wr_data,
            128'h1122_3344_5566_7788_1122_3344_5566_7788);
        chk("w1_bvalid_next", 128'(bvalid), 128'd1);
        @(negedge clk);
        chk("w1_en_pulse", 128'(wr_en), 128'd0);
        b_phase(2'b00, 1'b1, "w1");
        chk("w1_count", 128'(wren_cnt - w0), 128'd1);

        // Low-lane write with partial strobes.
        aw_phase(32'h100, 8'd0, 1'b0);
        w_beat(64'hCAFE, 8'h0F, 1'b1);
        chk("w2_strb", 128'(wr_strb), 128'h000F);
        b_phase(2'b00, 1'b0, "w2");

        // INCR read of 4 beats, beat index 1 back-pressured 5 cycles.
        r0 = rden_cnt;
        ar_phase(32'h200, 8'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                rready = 1'b0;
                wait_hi(4, "stall_rvalid");
                hold = rdata;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_rvalid_hold", 128'(rvalid), 128'd1);
                    chk("stall_rdata_hold", 128'(rdata), 128'(hold));
                end
            end
            r_beat(d, l, i);
            chk($sformatf("rd%0d_data", k), 128'(d), 128'(exp_d[k]));
            chk($sformatf("rd%0d_last", k), 128'(l), 128'(k == 3));
            chk($sformatf("rd%0d_id", k), 128'(i), 128'd1);
        end
        chk("rd_en_count", 128'(rden_cnt - r0), 128'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rd%0d_addr", k), 128'(rd_log[r0 + k]),
                128'(exp_a[k]));

        // Length mismatch: awlen 3, wlast on second beat.
        w0 = wren_cnt;
        aw_phase(32'h300, 8'd3, 1'b0);
        w_beat(64'h1, 8'hFF, 1'b0);
        w_beat(64'h2, 8'hFF, 1'b1);
        chk("short_bvalid_next", 128'(bvalid), 128'd1);
        b_phase(2'b10, 1'b0, "short");
        chk("short_count", 128'(wren_cnt - w0), 128'd2);

        // Start address at ADDR_LIMIT.
        w0 = wren_cnt;
        aw_phase(32'h0001_0000, 8'd1, 1'b1);
        w_beat(64'h3, 8'hFF, 1'b0);
        w_beat(64'h4, 8'hFF, 1'b1);
`ifdef AXI_SLV_DECERR_EN
        b_phase(2'b11, 1'b1, "lim");
        chk("lim_count", 128'(wren_cnt - w0), 128'd0);
`else
        b_phase(2'b00, 1'b1, "lim");
        chk("lim_count", 128'(wren_cnt - w0), 128'd2);
`endif

        // Simultaneous requests after reset: W, R, W.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            int t;
            awaddr = 32'h40; awlen = 0; awid = 1'b0;
            araddr = 32'h40; arlen = 0; arid = 1'b0;
            awvalid = 1'b1; arvalid = 1'b1;
            t = 0;
            while (!(awready || arready) && t < 50) begin
                @(negedge clk);
                t++;
            end
            g = awready;
            chk($sformatf("arb%0d_grant_w", k), 128'(g), 128'(k != 1));
            @(negedge clk);
            awvalid = 1'b0; arvalid = 1'b0;
            if (g) begin
                w_beat(64'h5, 8'hFF, 1'b1);
                b_phase(2'b00, 1'b0, "arb_w");
            end else begin
                r_beat(d, l, i);
                chk("arb_rdata", 128'(d), 128'h5555_0000_0000_0040);
                chk("arb_rlast", 128'(l), 128'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
